conv_encoder_framer: RTL and testbench

Streaming rate-1/2 convolutional encoder that sits directly upstream of the Viterbi decoder.
- Accepts a frame of information bits over a valid/ready handshake and encodes each bit into a 2-bit symbol {G0 parity, G1 parity}.
- Can optionally append K-1 zero tail bits to the frame.
- Can optionally flip symbol bits from an on-chip LFSR, giving a channel model for BER sweeps.
- Output symbols stream to the decoder's symbol loader with a per-frame done pulse and an injected-error count.

---
 rtl/conv_encoder_framer.sv | 174 +++++++++++++++++
 tb/tb_conv_encoder_framer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 convolutional encoder with frame control, optional zero-tail
// flush and LFSR-driven bit-flip injection for channel emulation.
module conv_encoder_framer #(
  parameter int unsigned    K       = 3,
  parameter logic [K-1:0]   G0      = 3'b111,
  parameter logic [K-1:0]   G1      = 3'b101,
  parameter bit             TAIL_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  frame_len,
  input  logic        noise_en,
  input  logic [15:0] noise_thresh,
  input  logic [15:0] lfsr_seed,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        in_ready,
  output logic        sym_valid,
  input  logic        sym_ready,
  output logic [1:0]  sym_out,
  output logic [8:0]  sym_idx,
  output logic [1:0]  sym_flip,
  output logic        busy,
  output logic        frame_done,
  output logic [8:0]  err_count
);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_TAIL, S_DRAIN, S_DONE} state_t;

  localparam logic [8:0]  TAIL_LEN  = 9'(K - 1);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  // Galois right-shift step, taps 0xB400
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  state_t      state_q;
  logic [K-2:0] st_q;
  logic [15:0] lfsr_q;
  logic [7:0]  len_q;
  logic        noise_en_q;
  logic [15:0] thresh_q;
  logic [8:0]  cnt_q;
  logic        sym_valid_q;
  logic [1:0]  sym_out_q;
  logic [1:0]  sym_flip_q;
  logic [8:0]  sym_idx_q;
  logic        busy_q;
  logic        frame_done_q;
  logic [8:0]  err_q;

  logic        slot_free;
  logic        data_left;
  logic        in_ready_d;
  logic        consume;
  logic        bit_d;
  logic [K-1:0] reg_d;
  logic [1:0]  sym_d;
  logic [K-2:0] st_d;
  logic [15:0] lfsr_1;
  logic [15:0] lfsr_2;
  logic [1:0]  flip_d;
  logic [1:0]  pop_d;
  logic [9:0]  err_sum;
  logic [8:0]  err_d;
  logic [8:0]  cnt_inc;
  logic [8:0]  data_end;
  logic [8:0]  tail_end;

  // The output slot can take a new symbol when empty or being drained now.
  // in_ready is also gated by the remaining-bit count so a zero-length
  // frame never accepts a bit during its single DATA cycle.
  assign slot_free  = !sym_valid_q || sym_ready;
  assign data_end   = {1'b0, len_q};
  assign tail_end   = data_end + TAIL_LEN;
  assign data_left  = (cnt_q != data_end);
  assign in_ready_d = (state_q == S_DATA) && data_left && slot_free;
  assign consume    = (in_ready_d && in_valid) || ((state_q == S_TAIL) && slot_free);
  assign cnt_inc    = cnt_q + 9'd1;

  // Encoder datapath: r = {st, b}, newest bit in the LSB
  assign bit_d = (state_q == S_DATA) ? in_bit : 1'b0;
  assign reg_d = {st_q, bit_d};
  assign sym_d = {^(reg_d & G0), ^(reg_d & G1)};
  assign st_d  = reg_d[K-2:0];

  // Two LFSR steps per symbol: first governs bit 0, second bit 1
  assign lfsr_1  = lfsr_step(lfsr_q);
  assign lfsr_2  = lfsr_step(lfsr_1);
  assign flip_d  = noise_en_q ? {(lfsr_2 < thresh_q), (lfsr_1 < thresh_q)} : 2'b00;
  assign pop_d   = {1'b0, flip_d[1]} + {1'b0, flip_d[0]};
  assign err_sum = {1'b0, err_q} + {8'd0, pop_d};
  assign err_d   = err_sum[9] ? 9'h1FF : err_sum[8:0];

  // Frame FSM together with the one-deep output register and noise state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      st_q         <= '0;
      lfsr_q       <= LFSR_INIT;
      len_q        <= '0;
      noise_en_q   <= 1'b0;
      thresh_q     <= '0;
      cnt_q        <= '0;
      sym_valid_q  <= 1'b0;
      sym_out_q    <= '0;
      sym_flip_q   <= '0;
      sym_idx_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (consume) begin
        sym_valid_q <= 1'b1;
        sym_out_q   <= sym_d ^ flip_d;
        sym_flip_q  <= flip_d;
        sym_idx_q   <= cnt_q;
        cnt_q       <= cnt_inc;
        st_q        <= st_d;
        err_q       <= err_d;
        if (noise_en_q) lfsr_q <= lfsr_2;
      end else if (sym_ready) begin
        sym_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_DATA;
            busy_q     <= 1'b1;
            st_q       <= '0;
            err_q      <= '0;
            cnt_q      <= '0;
            len_q      <= frame_len;
            noise_en_q <= noise_en;
            thresh_q   <= noise_thresh;
            lfsr_q     <= (lfsr_seed == 16'h0000) ? LFSR_INIT : lfsr_seed;
          end
        end
        S_DATA: begin
          if (!data_left || (consume && (cnt_inc == data_end)))
            state_q <= TAIL_EN ? S_TAIL : S_DRAIN;
        end
        S_TAIL: begin
          if (consume && (cnt_inc == tail_end)) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (slot_free) begin
            state_q      <= S_DONE;
            frame_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_d;
  assign sym_valid  = sym_valid_q;
  assign sym_out    = sym_out_q;
  assign sym_idx    = sym_idx_q;
  assign sym_flip   = sym_flip_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed bench for conv_encoder_framer: three instances cover K=3 without
// tail, K=3 with tail and K=5 with tail; one is selected per scenario.
module tb_conv_encoder_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = 3'b000;
  logic [7:0]  frame_len = 8'd0;
  logic        noise_en = 1'b0;
  logic [15:0] noise_thresh = 16'd0;
  logic [15:0] lfsr_seed = 16'd0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        sym_ready = 1'b1;

  logic [2:0]  in_ready_v, sym_valid_v, busy_v, frame_done_v;
  logic [1:0]  sym_out_v  [3];
  logic [1:0]  sym_flip_v [3];
  logic [8:0]  sym_idx_v  [3];
  logic [8:0]  err_v      [3];

  always #5 clk = ~clk;

  conv_encoder_framer #(.K(3), .G0(3'b111), .G1(3'b101), .TAIL_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .frame_len(frame_len),
    .noise_en(noise_en), .noise_thresh(noise_thresh), .lfsr_seed(lfsr_seed),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready_v[0]),
    .sym_valid(sym_valid_v[0]), .sym_ready(sym_ready), .sym_out(sym_out_v[0]),
    .sym_idx(sym_idx_v[0]), .sym_flip(sym_flip_v[0]), .busy(busy_v[0]),
    .frame_done(frame_done_v[0]), .err_count(err_v[0]));

  conv_encoder_framer #(.K(3), .G0(3'b111), .G1(3'b101), .TAIL_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .frame_len(frame_len),
    .noise_en(noise_en), .noise_thresh(noise_thresh), .lfsr_seed(lfsr_seed),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready_v[1]),
    .sym_valid(sym_valid_v[1]), .sym_ready(sym_ready), .sym_out(sym_out_v[1]),
    .sym_idx(sym_idx_v[1]), .sym_flip(sym_flip_v[1]), .busy(busy_v[1]),
    .frame_done(frame_done_v[1]), .err_count(err_v[1]));

  conv_encoder_framer #(.K(5), .G0(5'b10011), .G1(5'b11101), .TAIL_EN(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .frame_len(frame_len),
    .noise_en(noise_en), .noise_thresh(noise_thresh), .lfsr_seed(lfsr_seed),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready_v[2]),
    .sym_valid(sym_valid_v[2]), .sym_ready(sym_ready), .sym_out(sym_out_v[2]),
    .sym_idx(sym_idx_v[2]), .sym_flip(sym_flip_v[2]), .busy(busy_v[2]),
    .frame_done(frame_done_v[2]), .err_count(err_v[2]));

  // Selected-instance view
  logic [1:0] sel = 2'd0;
  logic       m_in_ready, m_sym_valid, m_busy, m_frame_done;
  logic [1:0] m_sym_out, m_sym_flip;
  logic [8:0] m_sym_idx, m_err;

  always_comb begin
    m_in_ready = in_ready_v[0]; m_sym_valid = sym_valid_v[0]; m_busy = busy_v[0];
    m_frame_done = frame_done_v[0]; m_sym_out = sym_out_v[0]; m_sym_flip = sym_flip_v[0];
    m_sym_idx = sym_idx_v[0]; m_err = err_v[0];
    case (sel)
      2'd1: begin
        m_in_ready = in_ready_v[1]; m_sym_valid = sym_valid_v[1]; m_busy = busy_v[1];
        m_frame_done = frame_done_v[1]; m_sym_out = sym_out_v[1]; m_sym_flip = sym_flip_v[1];
        m_sym_idx = sym_idx_v[1]; m_err = err_v[1];
      end
      2'd2: begin
        m_in_ready = in_ready_v[2]; m_sym_valid = sym_valid_v[2]; m_busy = busy_v[2];
        m_frame_done = frame_done_v[2]; m_sym_out = sym_out_v[2]; m_sym_flip = sym_flip_v[2];
        m_sym_idx = sym_idx_v[2]; m_err = err_v[2];
      end
      default: ;
    endcase
  end

  int errors = 0;
  int checks = 0;

  logic [255:0] tx_bits;
  logic [1:0]   q_sym[$];
  logic [1:0]   q_flip[$];
  logic [8:0]   q_idx[$];
  int n_done, done_at, stall_viol, rdy_viol, tail_rdy, timed_out;
  logic [15:0]  rpat = 16'b1001_0110_0100_1101;

  // Hand-computed clean symbols for bits 0,0,1,0,1,1,0,1 then tail 0,0
  logic [1:0] exp1 [10] = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11};

  function automatic logic [7:0] reg_of(input int k, input logic [7:0] st, input logic b);
    logic [7:0] m;
    m = 8'((1 << k) - 1);
    return ((st << 1) | {7'd0, b}) & m;
  endfunction

  function automatic logic [1:0] enc_sym(input int k, input logic [7:0] g0, input logic [7:0] g1,
                                         input logic [7:0] st, input logic b);
    logic [7:0] r;
    r = reg_of(k, st, b);
    return {^(r & g0), ^(r & g1)};
  endfunction

  function automatic logic [7:0] st_next(input int k, input logic [7:0] st, input logic b);
    return reg_of(k, st, b) & 8'((1 << (k - 1)) - 1);
  endfunction

  function automatic logic [15:0] lfsr_nx(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Starts a frame on instance s, drives bits and collects symbols.
  task automatic run_frame(input int s, input int len, input logic ne, input logic [15:0] thr,
                           input logic [15:0] seed, input int rmode, input int abort_n);
    int ptr, cyc;
    logic prev_stall;
    logic [1:0] p_out, p_flip;
    logic [8:0] p_idx;
    sel = 2'(s);
    q_sym.delete(); q_flip.delete(); q_idx.delete();
    n_done = 0; done_at = 0; stall_viol = 0; rdy_viol = 0; tail_rdy = 0; timed_out = 1;
    prev_stall = 1'b0; p_out = '0; p_flip = '0; p_idx = '0;
    @(negedge clk);
    frame_len = len[7:0]; noise_en = ne; noise_thresh = thr; lfsr_seed = seed;
    start_v = 3'b000; start_v[s] = 1'b1;
    @(negedge clk);
    start_v = 3'b000;
    ptr = 0; cyc = 0;
    while (cyc < 2000) begin
      cyc++;
      sym_ready = (rmode == 0) ? 1'b1 : rpat[cyc % 16];
      in_valid  = (ptr < len);
      in_bit    = (ptr < len) ? tx_bits[ptr] : 1'b0;
      #1;
      if (prev_stall && (m_sym_valid !== 1'b1 || m_sym_out !== p_out ||
                         m_sym_idx !== p_idx || m_sym_flip !== p_flip)) stall_viol++;
      if (m_sym_valid && !sym_ready && m_in_ready) rdy_viol++;
      if (ptr >= len && m_in_ready) tail_rdy++;
      if (m_sym_valid && sym_ready) begin
        q_sym.push_back(m_sym_out); q_flip.push_back(m_sym_flip); q_idx.push_back(m_sym_idx);
      end
      if (in_valid && m_in_ready) ptr++;
      if (m_frame_done === 1'b1) begin
        n_done++;
        if (done_at == 0) done_at = cyc;
      end
      prev_stall = m_sym_valid && !sym_ready;
      p_out = m_sym_out; p_flip = m_sym_flip; p_idx = m_sym_idx;
      if (abort_n > 0 && q_sym.size() >= abort_n) begin timed_out = 0; break; end
      if (done_at != 0 && cyc >= done_at + 2) begin timed_out = 0; break; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    sym_ready = 1'b1;
    $display("frame dut=%0d len=%0d symbols=%0d done_pulses=%0d err_count=%0d", s, len,
             q_sym.size(), n_done, m_err);
  endtask

  task automatic test_reset;
    sel = 2'd0;
    rst = 1'b1;
    #1;
    checks++; if (m_sym_valid !== 1'b0) begin errors++; $display("FAIL reset_sym_valid: got %b want 0", m_sym_valid); end
    checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", m_in_ready); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", m_busy); end
    checks++; if (m_frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", m_frame_done); end
    checks++; if (m_sym_out !== 2'b00) begin errors++; $display("FAIL reset_sym_out: got %b want 00", m_sym_out); end
    checks++; if (m_sym_idx !== 9'd0) begin errors++; $display("FAIL reset_sym_idx: got %0d want 0", m_sym_idx); end
    checks++; if (m_err !== 9'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", m_err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_clean_frame(input string tag, input int n_exp);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL %s_timeout: frame did not finish", tag); end
    checks++; if (q_sym.size() != n_exp) begin errors++; $display("FAIL %s_count: got %0d want %0d", tag, q_sym.size(), n_exp); end
    for (int i = 0; i < n_exp && i < q_sym.size(); i++) begin
      checks++; if (q_sym[i] !== exp1[i]) begin errors++; $display("FAIL %s_sym%0d: got %b want %b", tag, i, q_sym[i], exp1[i]); end
      checks++; if (q_idx[i] !== 9'(i)) begin errors++; $display("FAIL %s_idx%0d: got %0d want %0d", tag, i, q_idx[i], i); end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL %s_done_pulses: got %0d want 1", tag, n_done); end
    checks++; if (m_err !== 9'd0) begin errors++; $display("FAIL %s_err_count: got %0d want 0", tag, m_err); end
  endtask

  task automatic test_clean;
    tx_bits = '0; tx_bits[7:0] = 8'b10110100;
    run_frame(0, 8, 1'b0, 16'h0000, 16'h0000, 0, 0);
    check_clean_frame("clean", 8);
  endtask

  task automatic test_tail;
    tx_bits = '0; tx_bits[7:0] = 8'b10110100;
    run_frame(1, 8, 1'b0, 16'h0000, 16'h0000, 0, 0);
    check_clean_frame("tail", 10);
    checks++; if (tail_rdy != 0) begin errors++; $display("FAIL tail_in_ready: high %0d cycles after data, want 0", tail_rdy); end
  endtask

  task automatic test_back_to_back_backpressure;
    tx_bits = '0; tx_bits[7:0] = 8'b10110100;
    run_frame(0, 8, 1'b0, 16'h0000, 16'h0000, 1, 0);
    check_clean_frame("bp", 8);
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stall cycles, want 0", stall_viol); end
    checks++; if (rdy_viol != 0) begin errors++; $display("FAIL bp_in_ready: %0d cycles ready while stalled, want 0", rdy_viol); end
  endtask

  task automatic test_noise;
    logic [15:0] thr_tab [3] = '{16'h0000, 16'hFFFF, 16'h1000};
    logic [15:0] thr, lf, l1, l2;
    logic [7:0]  st;
    logic [1:0]  clean, f;
    int exp_err, bad_xor, bad_flip;
    tx_bits = '0; tx_bits[63:0] = 64'hDEAD_BEEF_0123_4567;
    for (int t = 0; t < 3; t++) begin
      thr = thr_tab[t];
      run_frame(0, 64, 1'b1, thr, 16'h1234, 0, 0);
      st = '0; lf = 16'h1234; exp_err = 0; bad_xor = 0; bad_flip = 0;
      for (int i = 0; i < 64; i++) begin
        clean = enc_sym(3, 8'h07, 8'h05, st, tx_bits[i]);
        st = st_next(3, st, tx_bits[i]);
        l1 = lfsr_nx(lf); l2 = lfsr_nx(l1); lf = l2;
        f = {(l2 < thr), (l1 < thr)};
        exp_err += int'(f[0]) + int'(f[1]);
        if (i < q_sym.size()) begin
          if ((q_sym[i] ^ clean) !== q_flip[i]) bad_xor++;
          if (q_flip[i] !== f) bad_flip++;
        end
      end
      checks++; if (q_sym.size() != 64) begin errors++; $display("FAIL noise%0d_count: got %0d want 64", t, q_sym.size()); end
      checks++; if (bad_xor != 0) begin errors++; $display("FAIL noise%0d_xor: %0d symbols where out^clean!=flip, want 0", t, bad_xor); end
      checks++; if (bad_flip != 0) begin errors++; $display("FAIL noise%0d_flip: %0d flip masks differ from model, want 0", t, bad_flip); end
      checks++; if (m_err !== 9'(exp_err)) begin errors++; $display("FAIL noise%0d_err_count: got %0d want %0d", t, m_err, exp_err); end
    end
  endtask

  task automatic test_boundary;
    logic [7:0] st;
    logic [1:0] e;
    int bad;
    tx_bits = '0;
    run_frame(0, 0, 1'b0, 16'h0000, 16'h0000, 0, 0);
    checks++; if (q_sym.size() != 0) begin errors++; $display("FAIL len0_count: got %0d want 0", q_sym.size()); end
    checks++; if (done_at != 3) begin errors++; $display("FAIL len0_done_latency: got %0d want 3", done_at); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL len0_done_pulses: got %0d want 1", n_done); end

    tx_bits = {8{32'hA5C3_961E}};
    run_frame(2, 255, 1'b0, 16'h0000, 16'h0000, 0, 0);
    checks++; if (q_sym.size() != 259) begin errors++; $display("FAIL len255_count: got %0d want 259", q_sym.size()); end
    if (q_idx.size() > 0) begin
      checks++; if (q_idx[q_idx.size()-1] !== 9'd258) begin errors++; $display("FAIL len255_last_idx: got %0d want 258", q_idx[q_idx.size()-1]); end
    end
    st = '0; bad = 0;
    for (int i = 0; i < 259; i++) begin
      e = enc_sym(5, 8'h13, 8'h1D, st, (i < 255) ? tx_bits[i] : 1'b0);
      st = st_next(5, st, (i < 255) ? tx_bits[i] : 1'b0);
      if (i < q_sym.size() && q_sym[i] !== e) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL len255_symbols: %0d differ from model, want 0", bad); end
  endtask

  task automatic test_reset_midframe;
    int fd;
    tx_bits = '0; tx_bits[7:0] = 8'b10110100;
    run_frame(0, 8, 1'b1, 16'h8000, 16'h5A5A, 0, 5);
    rst = 1'b1;
    #1;
    checks++; if (m_sym_valid !== 1'b0) begin errors++; $display("FAIL midrst_sym_valid: got %b want 0", m_sym_valid); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", m_busy); end
    checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b want 0", m_in_ready); end
    checks++; if (m_err !== 9'd0) begin errors++; $display("FAIL midrst_err_count: got %0d want 0", m_err); end
    checks++; if (m_sym_out !== 2'b00 || m_sym_idx !== 9'd0) begin errors++; $display("FAIL midrst_sym: got out=%b idx=%0d want 00/0", m_sym_out, m_sym_idx); end
    fd = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m_frame_done !== 1'b0 || m_busy !== 1'b0) fd++;
    end
    checks++; if (fd != 0) begin errors++; $display("FAIL midrst_hold: %0d cycles busy/done while in reset, want 0", fd); end
    rst = 1'b0;
    run_frame(0, 8, 1'b0, 16'h0000, 16'h0000, 0, 0);
    check_clean_frame("after_rst", 8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
    test_tail();
    test_back_to_back_backpressure();
    test_noise();
    test_boundary();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
